// File: rtl/bus_timer_slave.sv
// Bus-mapped 32-bit down-counting timer with prescaler, auto-reload and a
// registered level interrupt, behind a two-state request/acknowledge handshake.
module bus_timer_slave #(
  parameter int unsigned PRESCALE   = 16,
  parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [31:0] bus_writedata,
  input  logic [3:0]  bus_byteenable,
  output logic [31:0] bus_readdata,
  output logic [1:0]  bus_response,
  output logic        bus_waitrequest,
  output logic        irq_out
);

  localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [5:0]    off_q, off_d;
  logic          wr_q, wr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    resp_q, resp_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [31:0]   load_q, load_d;
  logic [31:0]   count_q, count_d;
  logic          expired_q, expired_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          irq_q, irq_d;

  logic        commit, wr_ctrl, wr_load, wr_count, clr_exp, tick, expire;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{bus_addr[31:8], bus_addr[1:0]};

  function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    case (bus_addr[7:2])
      6'd0:    rd_mux = {29'b0, ctrl_q};
      6'd1:    rd_mux = load_q;
      6'd2:    rd_mux = count_q;
      6'd3:    rd_mux = {31'b0, expired_q};
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    commit   = (state_q == ST_ACK) && wr_q;
    wr_ctrl  = commit && (off_q == 6'd0) && be_q[0];
    wr_load  = commit && (off_q == 6'd1);
    wr_count = commit && (off_q == 6'd2) && (|be_q);
    clr_exp  = commit && (off_q == 6'd3) && be_q[0] && wdata_q[0];
    tick     = ctrl_q[0] && (presc_q == PRESC_LAST);
    // a COUNT write in the same cycle swallows the tick entirely
    expire   = tick && !wr_count && (count_q == 32'd0);

    state_d = state_q;
    off_d   = off_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_read || bus_write) begin
          state_d = ST_ACK;
          off_d   = bus_addr[7:2];
          wr_d    = bus_write;
          wdata_d = bus_writedata;
          be_d    = bus_byteenable;
          rdata_d = bus_write ? 32'd0 : rd_mux;
          resp_d  = (bus_addr[7:2] > 6'd3) ? 2'b11 : 2'b00;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    presc_d = (!ctrl_q[0] || tick) ? '0 : presc_q + 1'b1;

    count_d = count_q;
    if (wr_count) begin
      count_d = lane_merge(count_q, wdata_q, be_q);
    end else if (tick) begin
      if (count_q != 32'd0)  count_d = count_q - 32'd1;
      else if (ctrl_q[1])    count_d = load_q;
    end

    ctrl_d = ctrl_q;
    if (expire && !ctrl_q[1]) ctrl_d[0] = 1'b0;
    if (wr_ctrl)              ctrl_d    = wdata_q[2:0];

    load_d    = wr_load ? lane_merge(load_q, wdata_q, be_q) : load_q;
    expired_d = (expired_q && !clr_exp) || expire;
    irq_d     = expired_q && ctrl_q[2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      off_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      ctrl_q    <= '0;
      load_q    <= RESET_LOAD;
      count_q   <= RESET_LOAD;
      expired_q <= 1'b0;
      presc_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      presc_q   <= presc_d;
      irq_q     <= irq_d;
    end
  end

  assign bus_waitrequest = (state_q != ST_ACK);
  assign bus_readdata    = rdata_q;
  assign bus_response    = resp_q;
  assign irq_out         = irq_q;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Randomized bench for bus_timer_slave against a cycle-level behavioural model
// of the register map and timer rules.
module tb_bus_timer_slave;
  localparam int P = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr;
  logic        bus_read, bus_write;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_readdata;
  logic [1:0]  bus_response;
  logic        bus_waitrequest;
  logic        irq_out;

  always #5 clk = ~clk;

  bus_timer_slave #(.PRESCALE(P), .RESET_LOAD(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_read(bus_read),
    .bus_write(bus_write), .bus_writedata(bus_writedata),
    .bus_byteenable(bus_byteenable), .bus_readdata(bus_readdata),
    .bus_response(bus_response), .bus_waitrequest(bus_waitrequest),
    .irq_out(irq_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [2:0]  m_ctrl;
  logic [31:0] m_load, m_count;
  logic        m_exp, m_irq;
  int          m_presc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_mix(input logic [31:0] cur, input logic [31:0] d,
                                           input logic [3:0] b);
    logic [31:0] mask;
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (cur & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] m_read(input logic [5:0] o);
    if (o == 6'd0) return {29'b0, m_ctrl};
    if (o == 6'd1) return m_load;
    if (o == 6'd2) return m_count;
    if (o == 6'd3) return {31'b0, m_exp};
    return 32'd0;
  endfunction

  task automatic m_reset();
    m_ctrl  = 3'b0;
    m_load  = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    m_exp   = 1'b0;
    m_irq   = 1'b0;
    m_presc = 0;
  endtask

  // one clock edge of the model; cm means a latched write commits at this edge
  task automatic m_edge(input bit cm, input logic [5:0] o, input logic [31:0] d,
                        input logic [3:0] b);
    logic irq_n;
    bit   en_old, tick, cw, set_e;
    irq_n   = m_exp & m_ctrl[2];
    en_old  = m_ctrl[0];
    tick    = en_old && (((m_presc + 1) % P) == 0);
    m_presc = en_old ? (m_presc + 1) % P : 0;
    cw      = cm && (o == 6'd2) && (b != 4'b0);
    set_e   = 1'b0;
    if (tick && !cw) begin
      if (m_count != 32'd0) m_count = m_count - 32'd1;
      else begin
        set_e = 1'b1;
        if (m_ctrl[1]) m_count = m_load;
        else           m_ctrl[0] = 1'b0;
      end
    end
    if (cm && o == 6'd0 && b[0]) m_ctrl = d[2:0];
    if (cm && o == 6'd1) m_load = lane_mix(m_load, d, b);
    if (cw) m_count = lane_mix(m_count, d, b);
    if (cm && o == 6'd3 && b[0] && d[0]) m_exp = 1'b0;
    if (set_e) m_exp = 1'b1;
    m_irq = irq_n;
  endtask

  task automatic cycle(input bit cm, input logic [5:0] o, input logic [31:0] d,
                       input logic [3:0] b);
    @(posedge clk);
    if (rst) m_reset();
    else     m_edge(cm, o, d, b);
    #1;
    chk("irq_out", {31'b0, irq_out}, {31'b0, m_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 6'd0, 32'd0, 4'd0);
  endtask

  task automatic xfer(input bit rd, input bit wr, input logic [5:0] o,
                      input logic [31:0] d, input logic [3:0] b, output logic [31:0] rdat);
    logic [31:0] r, er;
    logic [1:0]  eresp;
    r = $urandom();
    bus_addr       = {r[31:8], o, r[1:0]};
    bus_read       = rd;
    bus_write      = wr;
    bus_writedata  = d;
    bus_byteenable = b;
    er    = wr ? 32'd0 : m_read(o);
    eresp = (o > 6'd3) ? 2'b11 : 2'b00;
    chk("wait_req", {31'b0, bus_waitrequest}, 32'd1);
    cycle(1'b0, 6'd0, 32'd0, 4'd0);
    chk("wait_ack", {31'b0, bus_waitrequest}, 32'd0);
    chk("readdata", bus_readdata, er);
    chk("response", {30'b0, bus_response}, {30'b0, eresp});
    rdat = bus_readdata;
    cycle(wr, o, d, b);
    bus_read  = 1'b0;
    bus_write = 1'b0;
    chk("wait_done", {31'b0, bus_waitrequest}, 32'd1);
    chk("rdata_hold", bus_readdata, er);
  endtask

  task automatic wr_reg(input logic [5:0] o, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] dummy;
    xfer(1'b0, 1'b1, o, d, b, dummy);
  endtask

  task automatic rd_reg(input logic [5:0] o, output logic [31:0] v);
    xfer(1'b1, 1'b0, o, 32'd0, 4'd0, v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, d;
    logic [5:0]  o;
    logic [3:0]  b;
    int          guard, kind;

    rst = 1'b1; bus_addr = '0; bus_read = 1'b0; bus_write = 1'b0;
    bus_writedata = '0; bus_byteenable = '0;
    m_reset();
    idle(3);
    rst = 1'b0;
    chk("rst_wait", {31'b0, bus_waitrequest}, 32'd1);
    chk("rst_rdata", bus_readdata, 32'd0);
    chk("rst_resp", {30'b0, bus_response}, 32'd0);
    idle(1);

    rd_reg(6'd2, v);
    chk("rst_count", v, 32'hFFFF_FFFF);
    rd_reg(6'd0, v);
    chk("rst_ctrl", v, 32'd0);

    wr_reg(6'd2, 32'hAABB_CCDD, 4'b0101);
    rd_reg(6'd2, v);
    chk("lane_merge", v, 32'hFFBB_FFDD);

    // unmapped offset 0x40 and simultaneous read+write
    wr_reg(6'd16, 32'hFFFF_FFFF, 4'hF);
    rd_reg(6'd16, v);
    chk("unmapped_rd", v, 32'd0);
    xfer(1'b1, 1'b1, 6'd1, 32'h0000_1234, 4'hF, v);
    chk("rw_both_rd", v, 32'd0);
    rd_reg(6'd1, v);
    chk("rw_both_load", v, 32'h0000_1234);

    // auto-reload run
    wr_reg(6'd1, 32'd3, 4'hF);
    wr_reg(6'd2, 32'd3, 4'hF);
    wr_reg(6'd0, 32'd7, 4'hF);
    guard = 0;
    while (!m_irq && guard < 200) begin idle(1); guard++; end
    chk("ar_expire_bound", {31'b0, m_irq}, 32'd1);
    idle(20);
    rd_reg(6'd3, v);
    chk("ar_status", v, 32'd1);
    idle(P * 5);
    rd_reg(6'd0, v);
    chk("ar_ctrl_en", v, 32'd7);
    wr_reg(6'd3, 32'd1, 4'hF);
    idle(2);
    chk("irq_clear", {31'b0, irq_out}, 32'd0);

    // one-shot expiry colliding with W1C: set wins
    wr_reg(6'd0, 32'd0, 4'hF);
    wr_reg(6'd3, 32'd1, 4'hF);
    wr_reg(6'd2, 32'd0, 4'hF);
    wr_reg(6'd0, 32'd5, 4'hF);
    guard = 0;
    while (m_presc != P - 2 && guard < 100) begin idle(1); guard++; end
    chk("align_bound", m_presc, P - 2);
    wr_reg(6'd3, 32'd1, 4'hF);
    rd_reg(6'd3, v);
    chk("set_wins", v, 32'd1);
    rd_reg(6'd0, v);
    chk("oneshot_ctrl", v, 32'd4);
    chk("oneshot_irq", {31'b0, irq_out}, 32'd1);
    wr_reg(6'd3, 32'd1, 4'hF);
    idle(2);
    chk("w1c_irq", {31'b0, irq_out}, 32'd0);

    // reset during the acknowledge cycle
    bus_addr = {24'd0, 6'd0, 2'd0}; bus_write = 1'b1; bus_read = 1'b0;
    bus_writedata = 32'd7; bus_byteenable = 4'hF;
    idle(1);
    chk("pre_rst_ack", {31'b0, bus_waitrequest}, 32'd0);
    rst = 1'b1;
    idle(1);
    bus_write = 1'b0;
    rst = 1'b0;
    chk("rst_mid_wait", {31'b0, bus_waitrequest}, 32'd1);
    idle(1);
    rd_reg(6'd0, v);
    chk("rst_mid_ctrl", v, 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      o = ($urandom_range(0, 9) < 9) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(4, 63));
      d = $urandom();
      if ((o == 6'd1 || o == 6'd2) && $urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 6));
      b = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom_range(0, 15));
      kind = $urandom_range(0, 9);
      if (kind < 5)      xfer(1'b1, 1'b0, o, d, b, v);
      else if (kind < 9) xfer(1'b0, 1'b1, o, d, b, v);
      else               xfer(1'b1, 1'b1, o, d, b, v);
      idle($urandom_range(0, 12));
    end
    for (int r = 0; r < 4; r++) begin
      rd_reg(6'(r), v);
      chk("final_reg", v, m_read(6'(r)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
